// File: rtl/qs_srt_ucode_seq_if.sv
// Bundle of control-store, datapath-issue, BLINK, queue and emit signals
// exchanged between the sort microcode sequencer and its environment.
interface qs_srt_ucode_seq_if #(
    parameter int PC_W = 8
);
    // Control-store fetch
    logic [PC_W-1:0] ra;
    logic [15:0]     rout;

    // Datapath issue handshake
    logic            inst_vld;
    logic            inst_rdy;
    logic [15:0]     inst;

    // Condition flags from the datapath
    logic            flags_vld;
    logic            flags_eq;
    logic            flags_gt;

    // Link register (BLINK) access for CALL/RET
    logic            blink_we;
    logic [PC_W-1:0] blink_wdata;
    logic            blink_vld;
    logic [PC_W-1:0] blink_rdata;

    // Input-queue status and sorted-bank handoff
    logic            queue_ready;
    logic            emit_vld;
    logic            emit_rdy;

    // Status
    logic            busy;
    logic            err;

    // Sequencer side
    modport master (
        output ra,
        input  rout,
        output inst_vld,
        input  inst_rdy,
        output inst,
        input  flags_vld,
        input  flags_eq,
        input  flags_gt,
        output blink_we,
        output blink_wdata,
        input  blink_vld,
        input  blink_rdata,
        input  queue_ready,
        output emit_vld,
        input  emit_rdy,
        output busy,
        output err
    );

    // Environment side (control store, datapath, BLINK, queue)
    modport slave (
        input  ra,
        output rout,
        input  inst_vld,
        output inst_rdy,
        input  inst,
        output flags_vld,
        output flags_eq,
        output flags_gt,
        input  blink_we,
        input  blink_wdata,
        output blink_vld,
        output blink_rdata,
        output queue_ready,
        input  emit_vld,
        output emit_rdy,
        input  busy,
        input  err
    );
endinterface

// File: rtl/qs_srt_ucode_seq.sv
// Microcode sequencer for the sort engine. The PC drives the control-store
// address directly and the returned word is decoded in the same cycle, so an
// unstalled program retires one instruction per clock. Datapath ops are
// forwarded over a valid/ready handshake; control ops (jumps, CALL/RET,
// WAIT, EMIT) are executed locally and never reach the datapath.
module qs_srt_ucode_seq #(
    parameter int PC_W   = 8,
    parameter int PC_ERR = 128
) (
    input  logic                  clk,
    input  logic                  arst_n,
    qs_srt_ucode_seq_if.master    bus
);

    typedef logic [PC_W-1:0] pc_t;

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_WAIT_Q = 2'd1,
        S_EMIT   = 2'd2,
        S_ERR    = 2'd3
    } state_t;

    localparam pc_t PC_ERR_A = pc_t'(PC_ERR);

    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_JCC  = 4'b0001;
    localparam logic [3:0] OP_STK  = 4'b0010;
    localparam logic [3:0] OP_MEM  = 4'b0100;
    localparam logic [3:0] OP_MOV  = 4'b0110;
    localparam logic [3:0] OP_ALU  = 4'b0111;
    localparam logic [3:0] OP_CTL  = 4'b1100;
    localparam logic [3:0] OP_SYS  = 4'b1111;

    state_t state_q, state_d;
    pc_t    pc_q, pc_d;

    // Decoded fields of the word currently on rout
    logic [3:0] op;
    logic [1:0] cc;
    pc_t        tgt;
    pc_t        pc_inc;
    logic       sub_bit;
    logic       is_dp;
    logic       is_call;
    logic       jcc_ready;
    logic       jcc_take;
    logic       run_live;

    // Instruction decode and branch-condition evaluation
    always_comb begin
        op       = bus.rout[15:12];
        sub_bit  = bus.rout[11];
        cc       = bus.rout[9:8];
        tgt      = pc_t'(bus.rout[7:0]);
        // Natural wrap modulo 2^PC_W; falling off the top is not an error
        pc_inc   = pc_q + pc_t'(1);
        is_dp    = (op == OP_STK) || (op == OP_MEM) ||
                   (op == OP_MOV) || (op == OP_ALU);
        is_call  = (op == OP_CTL) && !sub_bit;
        // Unconditional jumps never wait on the flags
        jcc_ready = (cc == 2'b00) || bus.flags_vld;
        case (cc)
            2'b00:   jcc_take = 1'b1;
            2'b01:   jcc_take = bus.flags_eq;
            2'b10:   jcc_take = bus.flags_gt;
            default: jcc_take = !bus.flags_gt;
        endcase
        // Instruction at rout is only executed in RUN and not at the error
        // vector; reset also kills every outgoing strobe immediately.
        run_live = arst_n && (state_q == S_RUN) && (pc_q != PC_ERR_A);
    end

    // State and PC registers
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= S_RUN;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // Next state and next PC
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        case (state_q)
            S_RUN: begin
                if (pc_q == PC_ERR_A) begin
                    // Landing on the error vector traps without executing it
                    state_d = S_ERR;
                end else begin
                    case (op)
                        OP_NOP: begin
                            pc_d = pc_inc;
                        end
                        OP_JCC: begin
                            if (jcc_ready) begin
                                pc_d = jcc_take ? tgt : pc_inc;
                            end
                        end
                        OP_STK, OP_MEM, OP_MOV, OP_ALU: begin
                            // inst_vld is high here, so inst_rdy completes the issue
                            if (bus.inst_rdy) begin
                                pc_d = pc_inc;
                            end
                        end
                        OP_CTL: begin
                            if (!sub_bit) begin
                                pc_d = tgt;
                            end else if (bus.blink_vld) begin
                                pc_d = bus.blink_rdata;
                            end
                        end
                        OP_SYS: begin
                            // PC parks on WAIT/EMIT and advances on exit
                            state_d = sub_bit ? S_EMIT : S_WAIT_Q;
                        end
                        default: begin
                            state_d = S_ERR;
                        end
                    endcase
                end
            end
            S_WAIT_Q: begin
                if (bus.queue_ready) begin
                    state_d = S_RUN;
                    pc_d    = pc_inc;
                end
            end
            S_EMIT: begin
                if (bus.emit_rdy) begin
                    state_d = S_RUN;
                    pc_d    = pc_inc;
                end
            end
            default: begin
                // S_ERR: frozen until reset
                state_d = S_ERR;
                pc_d    = pc_q;
            end
        endcase
    end

    // Moore/Mealy outputs; strobes are gated so none escapes during reset
    always_comb begin
        bus.ra          = pc_q;
        bus.inst        = bus.rout;
        bus.inst_vld    = run_live && is_dp;
        bus.blink_we    = run_live && is_call;
        bus.blink_wdata = pc_inc;
        bus.emit_vld    = arst_n && (state_q == S_EMIT);
        bus.busy        = (state_q != S_WAIT_Q);
        bus.err         = (state_q == S_ERR);
    end

endmodule

// File: tb/tb_qs_srt_ucode_seq.sv
// Directed bench for the sort microcode sequencer: a small program image in a
// bench-side ROM is walked through boot, WAIT, CALL/RET, stalls, EMIT,
// illegal-opcode trap, error vector, PC wrap and reset abort.
module tb_qs_srt_ucode_seq;

    logic        clk;
    logic        arst_n;
    logic [15:0] rom [0:255];
    int          n_cmp;
    int          n_bad;

    qs_srt_ucode_seq_if #(.PC_W(8)) bus ();

    qs_srt_ucode_seq #(.PC_W(8), .PC_ERR(128)) dut (
        .clk    (clk),
        .arst_n (arst_n),
        .bus    (bus)
    );

    assign bus.rout = rom[bus.ra];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic release_reset();
        @(negedge clk);
        arst_n = 1'b1;
        #1;
    endtask

    task automatic load_program();
        for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
        rom[0]   = 16'h1060;                       // J always -> 96
        for (int i = 0; i < 8; i++) rom[96 + i] = 16'h6000 + 16'(i); // MOVI x8
        rom[104] = 16'hF000;                       // WAIT
        rom[105] = 16'h0000;                       // NOP
        rom[106] = 16'h0000;                       // NOP
        rom[107] = 16'hC040;                       // CALL 64
        rom[64]  = 16'h2000;                       // PUSH
        rom[65]  = 16'h0000;                       // NOP
        rom[66]  = 16'h1110;                       // J eq -> 16
        rom[71]  = 16'h1350;                       // J le (!gt) -> 80
        rom[80]  = 16'hF800;                       // EMIT
        rom[81]  = 16'hC800;                       // RET
        rom[108] = 16'h7000;                       // ADD
        rom[109] = 16'h3000;                       // illegal
    endtask

    task automatic test_reset();
        arst_n = 1'b0;
        #12;
        n_cmp++; if (bus.ra !== 8'd0)    begin n_bad++; $display("FAIL rst_ra: got %0d want 0", bus.ra); end
        n_cmp++; if (bus.inst_vld !== 1'b0) begin n_bad++; $display("FAIL rst_inst_vld: got %b want 0", bus.inst_vld); end
        n_cmp++; if (bus.blink_we !== 1'b0) begin n_bad++; $display("FAIL rst_blink_we: got %b want 0", bus.blink_we); end
        n_cmp++; if (bus.emit_vld !== 1'b0) begin n_bad++; $display("FAIL rst_emit_vld: got %b want 0", bus.emit_vld); end
        n_cmp++; if (bus.err !== 1'b0)   begin n_bad++; $display("FAIL rst_err: got %b want 0", bus.err); end
        n_cmp++; if (bus.busy !== 1'b1)  begin n_bad++; $display("FAIL rst_busy: got %b want 1", bus.busy); end
    endtask

    task automatic test_boot_movi();
        release_reset();
        n_cmp++; if (bus.ra !== 8'd0) begin n_bad++; $display("FAIL boot_ra0: got %0d want 0", bus.ra); end
        tick();
        for (int i = 0; i < 8; i++) begin
            n_cmp++; if (bus.ra !== 8'(96 + i)) begin n_bad++; $display("FAIL movi_ra[%0d]: got %0d want %0d", i, bus.ra, 96 + i); end
            n_cmp++; if (bus.inst_vld !== 1'b1) begin n_bad++; $display("FAIL movi_vld[%0d]: got %b want 1", i, bus.inst_vld); end
            n_cmp++; if (bus.inst !== 16'h6000 + 16'(i)) begin n_bad++; $display("FAIL movi_inst[%0d]: got %h want %h", i, bus.inst, 16'h6000 + 16'(i)); end
            tick();
        end
        n_cmp++; if (bus.ra !== 8'd104) begin n_bad++; $display("FAIL wait_ra: got %0d want 104", bus.ra); end
        n_cmp++; if (bus.inst_vld !== 1'b0) begin n_bad++; $display("FAIL wait_vld: got %b want 0", bus.inst_vld); end
        n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL wait_busy_run: got %b want 1", bus.busy); end
        tick();
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL waitq_busy: got %b want 0", bus.busy); end
        n_cmp++; if (bus.ra !== 8'd104) begin n_bad++; $display("FAIL waitq_ra: got %0d want 104", bus.ra); end
    endtask

    task automatic test_wait_call();
        for (int c = 0; c < 10; c++) begin
            n_cmp++; if (bus.ra !== 8'd104 || bus.busy !== 1'b0) begin n_bad++; $display("FAIL waitq_hold[%0d]: ra %0d busy %b want 104 0", c, bus.ra, bus.busy); end
            tick();
        end
        bus.queue_ready = 1'b1;
        tick();
        bus.queue_ready = 1'b0;
        #1;
        n_cmp++; if (bus.ra !== 8'd105) begin n_bad++; $display("FAIL waitq_exit_ra: got %0d want 105", bus.ra); end
        n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL waitq_exit_busy: got %b want 1", bus.busy); end
        tick();
        tick();
        n_cmp++; if (bus.ra !== 8'd107) begin n_bad++; $display("FAIL call_ra: got %0d want 107", bus.ra); end
        n_cmp++; if (bus.blink_we !== 1'b1) begin n_bad++; $display("FAIL call_we: got %b want 1", bus.blink_we); end
        n_cmp++; if (bus.blink_wdata !== 8'd108) begin n_bad++; $display("FAIL call_wdata: got %0d want 108", bus.blink_wdata); end
        n_cmp++; if (bus.inst_vld !== 1'b0) begin n_bad++; $display("FAIL call_vld: got %b want 0", bus.inst_vld); end
        tick();
        n_cmp++; if (bus.ra !== 8'd64) begin n_bad++; $display("FAIL call_tgt: got %0d want 64", bus.ra); end
        n_cmp++; if (bus.blink_we !== 1'b0) begin n_bad++; $display("FAIL call_we_drop: got %b want 0", bus.blink_we); end
    endtask

    task automatic test_inst_stall();
        bus.inst_rdy = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            n_cmp++; if (bus.ra !== 8'd64 || bus.inst_vld !== 1'b1 || bus.inst !== 16'h2000) begin
                n_bad++; $display("FAIL push_stall[%0d]: ra %0d vld %b inst %h want 64 1 2000", c, bus.ra, bus.inst_vld, bus.inst);
            end
            tick();
        end
        bus.inst_rdy = 1'b1;
        #1;
        n_cmp++; if (bus.ra !== 8'd64 || bus.inst_vld !== 1'b1) begin n_bad++; $display("FAIL push_issue: ra %0d vld %b want 64 1", bus.ra, bus.inst_vld); end
        tick();
        n_cmp++; if (bus.ra !== 8'd65) begin n_bad++; $display("FAIL push_next: got %0d want 65", bus.ra); end
    endtask

    task automatic test_jcc();
        tick();
        n_cmp++; if (bus.ra !== 8'd66) begin n_bad++; $display("FAIL jeq_ra: got %0d want 66", bus.ra); end
        tick();
        n_cmp++; if (bus.ra !== 8'd67) begin n_bad++; $display("FAIL jeq_not_taken: got %0d want 67", bus.ra); end
        for (int c = 0; c < 4; c++) tick();
        bus.flags_vld = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_cmp++; if (bus.ra !== 8'd71 || bus.inst_vld !== 1'b0) begin n_bad++; $display("FAIL jle_stall[%0d]: ra %0d vld %b want 71 0", c, bus.ra, bus.inst_vld); end
            tick();
        end
        bus.flags_vld = 1'b1;
        bus.flags_gt  = 1'b0;
        #1;
        n_cmp++; if (bus.ra !== 8'd71) begin n_bad++; $display("FAIL jle_hold: got %0d want 71", bus.ra); end
        tick();
        n_cmp++; if (bus.ra !== 8'd80) begin n_bad++; $display("FAIL jle_taken: got %0d want 80", bus.ra); end
    endtask

    task automatic test_emit_ret();
        n_cmp++; if (bus.emit_vld !== 1'b0) begin n_bad++; $display("FAIL emit_pre: got %b want 0", bus.emit_vld); end
        tick();
        for (int c = 0; c < 4; c++) begin
            #1;
            n_cmp++; if (bus.emit_vld !== 1'b1 || bus.inst_vld !== 1'b0 || bus.ra !== 8'd80) begin
                n_bad++; $display("FAIL emit_wait[%0d]: evld %b ivld %b ra %0d want 1 0 80", c, bus.emit_vld, bus.inst_vld, bus.ra);
            end
            tick();
        end
        bus.emit_rdy = 1'b1;
        #1;
        n_cmp++; if (bus.emit_vld !== 1'b1) begin n_bad++; $display("FAIL emit_hs: got %b want 1", bus.emit_vld); end
        tick();
        bus.emit_rdy = 1'b0;
        #1;
        n_cmp++; if (bus.emit_vld !== 1'b0 || bus.ra !== 8'd81) begin n_bad++; $display("FAIL emit_done: evld %b ra %0d want 0 81", bus.emit_vld, bus.ra); end
        bus.blink_vld = 1'b0;
        for (int c = 0; c < 2; c++) begin
            #1;
            n_cmp++; if (bus.ra !== 8'd81) begin n_bad++; $display("FAIL ret_stall[%0d]: got %0d want 81", c, bus.ra); end
            tick();
        end
        bus.blink_vld = 1'b1;
        tick();
        n_cmp++; if (bus.ra !== 8'd108) begin n_bad++; $display("FAIL ret_ra: got %0d want 108", bus.ra); end
        n_cmp++; if (bus.inst_vld !== 1'b1 || bus.inst !== 16'h7000) begin n_bad++; $display("FAIL add_issue: vld %b inst %h want 1 7000", bus.inst_vld, bus.inst); end
    endtask

    task automatic test_illegal();
        tick();
        n_cmp++; if (bus.ra !== 8'd109 || bus.inst_vld !== 1'b0 || bus.err !== 1'b0) begin
            n_bad++; $display("FAIL ill_decode: ra %0d vld %b err %b want 109 0 0", bus.ra, bus.inst_vld, bus.err);
        end
        tick();
        n_cmp++; if (bus.err !== 1'b1) begin n_bad++; $display("FAIL ill_err: got %b want 1", bus.err); end
        tick();
        tick();
        n_cmp++; if (bus.ra !== 8'd109 || bus.err !== 1'b1 || bus.inst_vld !== 1'b0) begin
            n_bad++; $display("FAIL ill_frozen: ra %0d err %b vld %b want 109 1 0", bus.ra, bus.err, bus.inst_vld);
        end
        arst_n = 1'b0;
        #1;
        n_cmp++; if (bus.err !== 1'b0 || bus.ra !== 8'd0) begin n_bad++; $display("FAIL ill_clear: err %b ra %0d want 0 0", bus.err, bus.ra); end
    endtask

    task automatic test_pc_err();
        rom[0] = 16'h1080;                         // J always -> 128
        release_reset();
        tick();
        n_cmp++; if (bus.ra !== 8'd128 || bus.err !== 1'b0) begin n_bad++; $display("FAIL pcerr_enter: ra %0d err %b want 128 0", bus.ra, bus.err); end
        tick();
        n_cmp++; if (bus.err !== 1'b1) begin n_bad++; $display("FAIL pcerr_err: got %b want 1", bus.err); end
        tick();
        n_cmp++; if (bus.ra !== 8'd128) begin n_bad++; $display("FAIL pcerr_frozen: got %0d want 128", bus.ra); end
        arst_n = 1'b0;
        #1;
    endtask

    task automatic test_wrap();
        rom[0] = 16'h10FF;                         // J always -> 255, 255 is NOP
        release_reset();
        tick();
        n_cmp++; if (bus.ra !== 8'd255) begin n_bad++; $display("FAIL wrap_top: got %0d want 255", bus.ra); end
        tick();
        n_cmp++; if (bus.ra !== 8'd0 || bus.err !== 1'b0) begin n_bad++; $display("FAIL wrap_zero: ra %0d err %b want 0 0", bus.ra, bus.err); end
        arst_n = 1'b0;
        #1;
    endtask

    task automatic test_reset_abort();
        rom[0] = 16'hF800;                         // EMIT at reset vector
        release_reset();
        tick();
        n_cmp++; if (bus.emit_vld !== 1'b1) begin n_bad++; $display("FAIL abort_emit_up: got %b want 1", bus.emit_vld); end
        #1;
        arst_n = 1'b0;
        #1;
        n_cmp++; if (bus.emit_vld !== 1'b0 || bus.ra !== 8'd0 || bus.busy !== 1'b1) begin
            n_bad++; $display("FAIL abort_emit: evld %b ra %0d busy %b want 0 0 1", bus.emit_vld, bus.ra, bus.busy);
        end
        rom[0] = 16'h2000;                         // PUSH at address 0 while held in reset
        #1;
        n_cmp++; if (bus.inst_vld !== 1'b0) begin n_bad++; $display("FAIL rst_gate_vld: got %b want 0", bus.inst_vld); end
        rom[0] = 16'hC040;                         // CALL at address 0 while held in reset
        #1;
        n_cmp++; if (bus.blink_we !== 1'b0) begin n_bad++; $display("FAIL rst_gate_we: got %b want 0", bus.blink_we); end
        release_reset();
        n_cmp++; if (bus.blink_we !== 1'b1 || bus.blink_wdata !== 8'd1) begin
            n_bad++; $display("FAIL post_rst_call: we %b wdata %0d want 1 1", bus.blink_we, bus.blink_wdata);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        arst_n          = 1'b0;
        bus.inst_rdy    = 1'b1;
        bus.flags_vld   = 1'b1;
        bus.flags_eq    = 1'b0;
        bus.flags_gt    = 1'b0;
        bus.blink_vld   = 1'b1;
        bus.blink_rdata = 8'd108;
        bus.queue_ready = 1'b0;
        bus.emit_rdy    = 1'b0;
        load_program();

        test_reset();
        test_boot_movi();
        test_wait_call();
        test_inst_stall();
        test_jcc();
        test_emit_ret();
        test_illegal();
        test_pc_err();
        test_wrap();
        test_reset_abort();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
